// File: rtl/wb_write_buffer.sv
// wb_write_buffer: posted-write FIFO between the data cache Wishbone master and memory.
module wb_write_buffer #(
    parameter int AW    = 12,
    parameter int DEPTH = 4
) (
    input  logic          cpu_clock_i,
    input  logic          cpu_rst_ni,
    input  logic          s_cyc_i,
    input  logic          s_stb_i,
    input  logic          s_we_i,
    input  logic [AW-1:0] s_adr_i,
    input  logic [31:0]   s_dat_i,
    input  logic [3:0]    s_sel_i,
    output logic          s_stall_o,
    output logic          s_ack_o,
    output logic [31:0]   s_dat_o,
    output logic          s_err_o,
    output logic          m_cyc_o,
    output logic          m_stb_o,
    output logic          m_we_o,
    output logic [AW-1:0] m_adr_o,
    output logic [31:0]   m_dat_o,
    output logic [3:0]    m_sel_o,
    input  logic          m_stall_i,
    input  logic          m_ack_i,
    input  logic          m_err_i,
    input  logic [31:0]   m_dat_i,
    output logic          wr_err_o
);
    localparam int PW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, DRAIN, READ} state_t;
    state_t state, state_nx;
    logic [AW-1:0] adr_mem [DEPTH];
    logic [31:0] dat_mem [DEPTH];
    logic [3:0] sel_mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0] count;
    logic [AW-1:0] m_adr_q;
    logic [31:0] m_dat_q;
    logic [3:0] m_sel_q;
    logic full, rd, rd_req, push, pop, ack_q, m_cyc_q, m_stb_q, wr_err_q;

    assign full   = count == (PW+1)'(DEPTH);
    assign rd     = state == READ;
    assign rd_req = s_cyc_i & s_stb_i & ~s_we_i;
    assign push   = s_cyc_i & s_stb_i & s_we_i & ~full & ~rd;
    assign pop    = (state == DRAIN) & (m_ack_i | m_err_i);

    always_ff @(posedge cpu_clock_i or negedge cpu_rst_ni) begin
        if (!cpu_rst_ni) state <= IDLE;
        else state <= state_nx;
    end

    // Drain wins over a pending read so reads never overtake buffered writes.
    always_comb begin
        state_nx = state;
        if (state == IDLE) state_nx = |count ? DRAIN : rd_req ? READ : IDLE;
        else if (state == DRAIN) state_nx = (m_ack_i | m_err_i) ? IDLE : DRAIN;
        else if (!s_cyc_i) state_nx = IDLE;
    end

    always_comb begin
        s_stall_o = rd ? (s_stb_i & s_we_i) | m_stall_i : full | rd_req;
        s_ack_o   = rd ? m_ack_i : ack_q;
        s_dat_o   = rd ? m_dat_i : '0;
        s_err_o   = rd & m_err_i;
        m_cyc_o   = rd ? s_cyc_i : m_cyc_q;
        m_stb_o   = rd ? s_stb_i : m_stb_q;
        m_we_o    = m_cyc_q;
        m_adr_o   = rd ? s_adr_i : m_adr_q;
        m_dat_o   = m_dat_q;
        m_sel_o   = rd ? s_sel_i : m_sel_q;
        wr_err_o  = wr_err_q;
    end

    always_ff @(posedge cpu_clock_i) begin
        if (push) begin
            adr_mem[wr_ptr] <= s_adr_i;
            dat_mem[wr_ptr] <= s_dat_i;
            sel_mem[wr_ptr] <= s_sel_i;
        end
    end

    always_ff @(posedge cpu_clock_i or negedge cpu_rst_ni) begin
        if (!cpu_rst_ni) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            ack_q    <= 1'b0;
            wr_err_q <= 1'b0;
            m_cyc_q  <= 1'b0;
            m_stb_q  <= 1'b0;
            m_adr_q  <= '0;
            m_dat_q  <= '0;
            m_sel_q  <= '0;
        end else begin
            ack_q    <= push;
            wr_ptr   <= push ? wr_ptr + PW'(1) : wr_ptr;
            rd_ptr   <= pop ? rd_ptr + PW'(1) : rd_ptr;
            count    <= count + (PW+1)'(push) - (PW+1)'(pop);
            wr_err_q <= wr_err_q | (pop & m_err_i);
            if (state == IDLE && |count) begin
                m_cyc_q <= 1'b1;
                m_stb_q <= 1'b1;
                m_adr_q <= adr_mem[rd_ptr];
                m_dat_q <= dat_mem[rd_ptr];
                m_sel_q <= sel_mem[rd_ptr];
            end else if (state == DRAIN) begin
                m_stb_q <= m_stb_q & m_stall_i & ~m_ack_i & ~m_err_i;
                m_cyc_q <= ~(m_ack_i | m_err_i);
            end
        end
    end
endmodule

// File: tb/tb_wb_write_buffer.sv
// tb_wb_write_buffer: directed stimulus against an ordered-write / read-after-write reference model.
module tb_wb_write_buffer;
    localparam int AW = 12, DEPTH = 4;
    logic cpu_clock_i = 0, cpu_rst_ni = 0;
    logic s_cyc_i = 0, s_stb_i = 0, s_we_i = 0;
    logic [AW-1:0] s_adr_i = '0;
    logic [31:0] s_dat_i = '0;
    logic [3:0] s_sel_i = '0;
    logic s_stall_o, s_ack_o, s_err_o;
    logic [31:0] s_dat_o;
    logic m_cyc_o, m_stb_o, m_we_o;
    logic [AW-1:0] m_adr_o;
    logic [31:0] m_dat_o;
    logic [3:0] m_sel_o;
    logic m_stall_i = 0, m_ack_i = 0, m_err_i = 0;
    logic [31:0] m_dat_i = '0;
    logic wr_err_o;

    wb_write_buffer #(.AW(AW), .DEPTH(DEPTH)) dut (
        .cpu_clock_i(cpu_clock_i), .cpu_rst_ni(cpu_rst_ni),
        .s_cyc_i(s_cyc_i), .s_stb_i(s_stb_i), .s_we_i(s_we_i), .s_adr_i(s_adr_i),
        .s_dat_i(s_dat_i), .s_sel_i(s_sel_i), .s_stall_o(s_stall_o), .s_ack_o(s_ack_o),
        .s_dat_o(s_dat_o), .s_err_o(s_err_o), .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o),
        .m_we_o(m_we_o), .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_sel_o(m_sel_o),
        .m_stall_i(m_stall_i), .m_ack_i(m_ack_i), .m_err_i(m_err_i), .m_dat_i(m_dat_i),
        .wr_err_o(wr_err_o)
    );

    always #5 cpu_clock_i = ~cpu_clock_i;

    typedef struct {logic [AW-1:0] adr; logic [31:0] dat; logic [3:0] sel;} wr_t;
    typedef struct {int due; logic we; logic [AW-1:0] adr; logic err;} rsp_t;
    wr_t exp_wr[$];
    rsp_t rsp_q[$];
    logic [31:0] ref_mem [1<<AW];
    logic [31:0] phys_mem [1<<AW];
    int checks = 0, failures = 0;
    int mcount = 0, cyc_n = 0, lat = 1;
    bit prev_push = 0, exp_err = 0, err_en = 0, resp_we = 0;
    logic [AW-1:0] resp_adr = '0, err_adr = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
        for (int b = 0; b < 4; b++) if (s[b]) o[8*b +: 8] = n[8*b +: 8];
        return o;
    endfunction

    function automatic int writes_outstanding();
        int n = 0;
        foreach (rsp_q[i]) if (rsp_q[i].we) n++;
        return n;
    endfunction

    // Memory responder followed by the per-cycle comparison against the reference model.
    always begin : compare
        rsp_t r;
        wr_t w;
        bit push;
        @(negedge cpu_clock_i);
        m_ack_i = 0;
        m_err_i = 0;
        resp_we = 0;
        cyc_n++;
        if (!cpu_rst_ni) rsp_q.delete();
        else if (rsp_q.size() > 0 && rsp_q[0].due <= cyc_n) begin
            r = rsp_q.pop_front();
            resp_we = r.we;
            resp_adr = r.adr;
            if (r.err) m_err_i = 1; else m_ack_i = 1;
            m_dat_i = r.we ? 32'h0 : phys_mem[r.adr];
        end
        #1;
        if (!cpu_rst_ni) begin
            mcount = 0;
            prev_push = 0;
            exp_err = 0;
            exp_wr.delete();
        end else begin
            chk("s_ack", s_ack_o, prev_push || (m_ack_i && !resp_we));
            chk("wr_err", wr_err_o, exp_err);
            chk("s_err", s_err_o, 0);
            if (s_cyc_i && s_stb_i && s_we_i) chk("s_stall_wr", s_stall_o, mcount == DEPTH);
            if (m_ack_i && !resp_we) chk("rd_data", s_dat_o, ref_mem[resp_adr]);
            if (m_cyc_o && m_stb_o && !m_we_o) chk("raw_order", mcount, 0);
            if (m_cyc_o && m_stb_o && !m_stall_i) begin
                if (m_we_o) begin
                    chk("one_outstanding", writes_outstanding(), 0);
                    chk("wr_expected", exp_wr.size() > 0, 1);
                    if (exp_wr.size() > 0) begin
                        w = exp_wr.pop_front();
                        chk("wr_adr", m_adr_o, w.adr);
                        chk("wr_dat", m_dat_o, w.dat);
                        chk("wr_sel", m_sel_o, w.sel);
                    end
                    if (!(err_en && m_adr_o == err_adr))
                        phys_mem[m_adr_o] = merge(phys_mem[m_adr_o], m_dat_o, m_sel_o);
                end
                r.due = cyc_n + lat;
                r.we = m_we_o;
                r.adr = m_adr_o;
                r.err = err_en && m_we_o && m_adr_o == err_adr;
                rsp_q.push_back(r);
            end
            push = s_cyc_i && s_stb_i && s_we_i && !s_stall_o;
            if (push) begin
                w.adr = s_adr_i;
                w.dat = s_dat_i;
                w.sel = s_sel_i;
                exp_wr.push_back(w);
                ref_mem[s_adr_i] = merge(ref_mem[s_adr_i], s_dat_i, s_sel_i);
                mcount++;
            end
            if ((m_ack_i || m_err_i) && resp_we) mcount--;
            if (m_err_i && resp_we) exp_err = 1;
            prev_push = push;
        end
    end

    task automatic wr(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s);
        bit acc = 0;
        s_cyc_i = 1; s_stb_i = 1; s_we_i = 1;
        s_adr_i = a; s_dat_i = d; s_sel_i = s;
        for (int n = 0; n < 200 && !acc; n++) begin
            @(negedge cpu_clock_i); #2;
            acc = !s_stall_o;
            @(posedge cpu_clock_i); #1;
        end
        s_cyc_i = 0; s_stb_i = 0; s_we_i = 0;
        if (!acc) begin
            checks++; failures++;
            $display("FAIL wr_accept adr=0x%0h actual=stalled required=accepted", a);
        end
    endtask

    task automatic rd_burst(input logic [AW-1:0] a, input int len, output logic [31:0] d0, output int n_ack);
        int n_acc = 0;
        n_ack = 0;
        d0 = 'x;
        s_cyc_i = 1; s_stb_i = 1; s_we_i = 0; s_adr_i = a; s_sel_i = 4'hF;
        for (int n = 0; n < 300 && n_ack < len; n++) begin
            bit acc;
            @(negedge cpu_clock_i); #2;
            if (n_acc > 0 && s_ack_o) begin
                if (n_ack == 0) d0 = s_dat_o;
                n_ack++;
            end
            acc = s_stb_i && !s_stall_o;
            @(posedge cpu_clock_i); #1;
            if (acc) begin
                n_acc++;
                if (n_acc == len) s_stb_i = 0; else s_adr_i = s_adr_i + 1'b1;
            end
        end
        s_cyc_i = 0; s_stb_i = 0;
    endtask

    task automatic wait_drain();
        bit done = 0;
        for (int n = 0; n < 300 && !done; n++) begin
            @(posedge cpu_clock_i); #1;
            done = mcount == 0 && !m_cyc_o;
        end
        if (!done) begin
            checks++; failures++;
            $display("FAIL drain actual=busy required=idle");
        end
        @(posedge cpu_clock_i); #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "simulation timeout");
    end

    initial begin
        logic [31:0] d0;
        int n_ack;
        for (int i = 0; i < (1<<AW); i++) begin
            ref_mem[i] = {20'hA5000, i[11:0]};
            phys_mem[i] = {20'hA5000, i[11:0]};
        end
        repeat (2) @(posedge cpu_clock_i);
        #1;
        chk("rst_m_cyc", m_cyc_o, 0);
        chk("rst_m_stb", m_stb_o, 0);
        chk("rst_m_adr", m_adr_o, 0);
        chk("rst_s_ack", s_ack_o, 0);
        chk("rst_wr_err", wr_err_o, 0);
        chk("rst_s_stall", s_stall_o, 0);
        @(posedge cpu_clock_i); #1;
        cpu_rst_ni = 1;
        repeat (2) @(posedge cpu_clock_i); #1;

        // T1 single write
        wr(12'h010, 32'hDEADBEEF, 4'hF);
        chk("t1_ack", s_ack_o, 1);
        @(posedge cpu_clock_i); #1;
        chk("t1_cyc", m_cyc_o, 1);
        chk("t1_stb", m_stb_o, 1);
        chk("t1_we", m_we_o, 1);
        chk("t1_adr", m_adr_o, 12'h010);
        chk("t1_dat", m_dat_o, 32'hDEADBEEF);
        chk("t1_sel", m_sel_o, 4'hF);
        wait_drain();
        chk("t1_idle", m_cyc_o, 0);
        chk("t1_mem", phys_mem[12'h010], 32'hDEADBEEF);

        // T2 fill with memory stalled, fifth write waits for the first drain
        m_stall_i = 1;
        for (int i = 0; i < 4; i++) wr(12'h100 + 12'(i), 32'hA0A0_0000 + i, 4'hF);
        fork
            wr(12'h104, 32'hA0A0_0004, 4'hF);
            begin
                repeat (4) @(negedge cpu_clock_i);
                #2;
                chk("t2_full_stall", s_stall_o, 1);
                @(posedge cpu_clock_i); #1;
                m_stall_i = 0;
            end
        join
        chk("t2_fifth_ack", s_ack_o, 1);
        wait_drain();
        chk("t2_mem0", phys_mem[12'h100], 32'hA0A00000);
        chk("t2_mem4", phys_mem[12'h104], 32'hA0A00004);

        // T3 read-after-write burst
        wr(12'h020, 32'h12345678, 4'hF);
        rd_burst(12'h020, 4, d0, n_ack);
        chk("t3_data0", d0, 32'h12345678);
        chk("t3_acks", n_ack, 4);
        repeat (2) @(posedge cpu_clock_i); #1;

        // T4 write error is sticky
        err_en = 1;
        err_adr = 12'h030;
        wr(12'h030, 32'hCAFEF00D, 4'hF);
        wait_drain();
        chk("t4_err", wr_err_o, 1);
        err_en = 0;
        wr(12'h031, 32'h31313131, 4'hF);
        wr(12'h032, 32'h32323232, 4'h3);
        wait_drain();
        chk("t4_err_held", wr_err_o, 1);
        chk("t4_not_written", phys_mem[12'h030], 32'hA5000030);
        chk("t4_partial", phys_mem[12'h032], 32'hA5003232);

        // T5 asynchronous reset during a drain
        m_stall_i = 1;
        for (int i = 0; i < 3; i++) wr(12'h040 + 12'(i), 32'h4040_0000 + i, 4'hF);
        @(posedge cpu_clock_i); #1;
        chk("t5_in_flight", m_cyc_o, 1);
        #1 cpu_rst_ni = 0;
        #1;
        chk("t5_cyc_async", m_cyc_o, 0);
        chk("t5_err_cleared", wr_err_o, 0);
        repeat (2) @(posedge cpu_clock_i); #1;
        cpu_rst_ni = 1;
        m_stall_i = 0;
        repeat (8) @(posedge cpu_clock_i); #1;
        chk("t5_stall", s_stall_o, 0);
        chk("t5_no_stb", m_stb_o, 0);
        chk("t5_mem", phys_mem[12'h040], 32'hA5000040);

        // T6 push and pop on the same edge with two entries buffered
        lat = 2;
        m_stall_i = 1;
        wr(12'h050, 32'h60000000, 4'hF);
        wr(12'h051, 32'h60000001, 4'hF);
        fork
            for (int i = 2; i < 6; i++) wr(12'h050 + 12'(i), 32'h60000000 + i, 4'hF);
            begin
                @(posedge cpu_clock_i); #1;
                m_stall_i = 0;
            end
        join
        wait_drain();
        for (int i = 0; i < 6; i++) chk("t6_mem", phys_mem[12'h050 + 12'(i)], 32'h60000000 + i);
        lat = 1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
